// File: rtl/wb_commit_arb_pkg.sv
// Shared widths, source indices and buffer entry type for the
// long-instruction writeback/commit arbiter.
package wb_commit_arb_pkg;

  localparam int COMMIT_ID_WIDTH = 4;
  localparam int REG_ADDR_WIDTH  = 5;

  typedef enum logic [1:0] {
    SRC_MUL = 2'd0,
    SRC_DIV = 2'd1,
    SRC_LSU = 2'd2,
    SRC_CSR = 2'd3
  } src_e;

  typedef struct packed {
    logic [COMMIT_ID_WIDTH-1:0] id;
    logic                       we;
    logic [REG_ADDR_WIDTH-1:0]  addr;
    logic [31:0]                data;
  } entry_t;

endpackage

// File: rtl/wb_src_fifo.sv
// Per-source completion buffer; power-of-two depth, wrapping pointers,
// push while full is taken when the head pops in the same cycle.
module wb_src_fifo
  import wb_commit_arb_pkg::*;
#(
  parameter int BUF_DEPTH = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   i_push,
  input  entry_t i_entry,
  input  logic   i_pop,
  output entry_t o_head,
  output logic   o_full,
  output logic   o_empty
);

  localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  entry_t          r_mem [BUF_DEPTH];
  logic [AW-1:0]   r_wp;
  logic [AW-1:0]   r_rp;
  logic [AW:0]     r_cnt;
  logic            w_push;
  logic            w_pop;

  assign o_full  = (r_cnt == (AW+1)'(BUF_DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_head  = r_mem[r_rp];
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= i_entry;
  end

endmodule

// File: rtl/wb_commit_arb.sv
// Dual-port writeback/commit arbiter: round-robin picks up to two
// buffered completions per cycle and registers them onto the ports.
module wb_commit_arb
  import wb_commit_arb_pkg::*;
#(
  parameter int NSRC      = 4,
  parameter int BUF_DEPTH = 2
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NSRC-1:0]                        src_valid_i,
  output logic [NSRC-1:0]                        src_ready_o,
  input  logic [NSRC-1:0][COMMIT_ID_WIDTH-1:0]   src_id_i,
  input  logic [NSRC-1:0]                        src_rd_we_i,
  input  logic [NSRC-1:0][REG_ADDR_WIDTH-1:0]    src_rd_addr_i,
  input  logic [NSRC-1:0][31:0]                  src_rd_data_i,
  output logic                                   reg_we_o,
  output logic [REG_ADDR_WIDTH-1:0]              reg_waddr_o,
  output logic [31:0]                            reg_wdata_o,
  output logic                                   reg_we2_o,
  output logic [REG_ADDR_WIDTH-1:0]              reg_waddr2_o,
  output logic [31:0]                            reg_wdata2_o,
  output logic                                   commit_valid_o,
  output logic [COMMIT_ID_WIDTH-1:0]             commit_id_o,
  output logic                                   commit_valid2_o,
  output logic [COMMIT_ID_WIDTH-1:0]             commit_id2_o,
  output logic                                   busy_o
);

  localparam int PW = (NSRC > 1) ? $clog2(NSRC) : 1;

  logic [NSRC-1:0] w_full;
  logic [NSRC-1:0] w_empty;
  logic [NSRC-1:0] w_push;
  logic [NSRC-1:0] w_pop;
  entry_t          w_in   [NSRC];
  entry_t          w_head [NSRC];

  logic [PW-1:0]   r_rr;
  logic [PW-1:0]   w_rr_nxt;
  logic [PW-1:0]   w_g1;
  logic [PW-1:0]   w_g2;
  logic            w_g1_v;
  logic            w_g2_v;
  entry_t          w_e1;
  entry_t          w_e2;

  for (genvar s = 0; s < NSRC; s++) begin : g_src
    assign w_in[s] = '{id:   src_id_i[s],
                       we:   src_rd_we_i[s],
                       addr: src_rd_addr_i[s],
                       data: src_rd_data_i[s]};
    assign w_push[s] = src_valid_i[s] & ~w_full[s];

    wb_src_fifo #(.BUF_DEPTH(BUF_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push[s]),
      .i_entry (w_in[s]),
      .i_pop   (w_pop[s]),
      .o_head  (w_head[s]),
      .o_full  (w_full[s]),
      .o_empty (w_empty[s])
    );
  end

  assign src_ready_o = ~w_full;
  assign busy_o      = ~&w_empty;

  always_comb begin
    w_g1_v   = 1'b0;
    w_g2_v   = 1'b0;
    w_g1     = '0;
    w_g2     = '0;
    w_pop    = '0;
    w_rr_nxt = r_rr;
    for (int k = 0; k < NSRC; k++) begin
      int idx;
      idx = (int'(r_rr) + k) % NSRC;
      if (!w_empty[idx]) begin
        if (!w_g1_v) begin
          w_g1_v = 1'b1;
          w_g1   = PW'(idx);
        end else if (!w_g2_v) begin
          w_g2_v = 1'b1;
          w_g2   = PW'(idx);
        end
      end
    end
    w_e1 = w_head[w_g1];
    w_e2 = w_head[w_g2];
    // Same-rd pair in one cycle: defer the second so write order holds.
    if (w_g2_v && w_e1.we && w_e2.we &&
        (w_e1.addr == w_e2.addr) && (w_e1.addr != '0))
      w_g2_v = 1'b0;
    if (w_g1_v) w_pop[w_g1] = 1'b1;
    if (w_g2_v) w_pop[w_g2] = 1'b1;
    if (w_g2_v)
      w_rr_nxt = PW'((int'(w_g2) + 1) % NSRC);
    else if (w_g1_v)
      w_rr_nxt = PW'((int'(w_g1) + 1) % NSRC);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr            <= '0;
      reg_we_o        <= 1'b0;
      reg_waddr_o     <= '0;
      reg_wdata_o     <= '0;
      reg_we2_o       <= 1'b0;
      reg_waddr2_o    <= '0;
      reg_wdata2_o    <= '0;
      commit_valid_o  <= 1'b0;
      commit_id_o     <= '0;
      commit_valid2_o <= 1'b0;
      commit_id2_o    <= '0;
    end else begin
      r_rr            <= w_rr_nxt;
      reg_we_o        <= w_g1_v & w_e1.we & (w_e1.addr != '0);
      reg_waddr_o     <= w_g1_v ? w_e1.addr : '0;
      reg_wdata_o     <= w_g1_v ? w_e1.data : '0;
      reg_we2_o       <= w_g2_v & w_e2.we & (w_e2.addr != '0);
      reg_waddr2_o    <= w_g2_v ? w_e2.addr : '0;
      reg_wdata2_o    <= w_g2_v ? w_e2.data : '0;
      commit_valid_o  <= w_g1_v;
      commit_id_o     <= w_g1_v ? w_e1.id : '0;
      commit_valid2_o <= w_g2_v;
      commit_id2_o    <= w_g2_v ? w_e2.id : '0;
    end
  end

endmodule

// File: tb/tb_wb_commit_arb.sv
// Directed bench for wb_commit_arb: latency, dual grant, rd conflict,
// non-writing commits, streaming and mid-operation reset.
module tb_wb_commit_arb;
  import wb_commit_arb_pkg::*;

  localparam int NSRC = 4;

  logic                                 clk = 1'b0;
  logic                                 rst;
  logic [NSRC-1:0]                      src_valid_i;
  logic [NSRC-1:0]                      src_ready_o;
  logic [NSRC-1:0][COMMIT_ID_WIDTH-1:0] src_id_i;
  logic [NSRC-1:0]                      src_rd_we_i;
  logic [NSRC-1:0][REG_ADDR_WIDTH-1:0]  src_rd_addr_i;
  logic [NSRC-1:0][31:0]                src_rd_data_i;
  logic                                 reg_we_o;
  logic [REG_ADDR_WIDTH-1:0]            reg_waddr_o;
  logic [31:0]                          reg_wdata_o;
  logic                                 reg_we2_o;
  logic [REG_ADDR_WIDTH-1:0]            reg_waddr2_o;
  logic [31:0]                          reg_wdata2_o;
  logic                                 commit_valid_o;
  logic [COMMIT_ID_WIDTH-1:0]           commit_id_o;
  logic                                 commit_valid2_o;
  logic [COMMIT_ID_WIDTH-1:0]           commit_id2_o;
  logic                                 busy_o;

  int checks = 0;
  int errors = 0;

  wb_commit_arb #(.NSRC(NSRC), .BUF_DEPTH(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .src_valid_i     (src_valid_i),
    .src_ready_o     (src_ready_o),
    .src_id_i        (src_id_i),
    .src_rd_we_i     (src_rd_we_i),
    .src_rd_addr_i   (src_rd_addr_i),
    .src_rd_data_i   (src_rd_data_i),
    .reg_we_o        (reg_we_o),
    .reg_waddr_o     (reg_waddr_o),
    .reg_wdata_o     (reg_wdata_o),
    .reg_we2_o       (reg_we2_o),
    .reg_waddr2_o    (reg_waddr2_o),
    .reg_wdata2_o    (reg_wdata2_o),
    .commit_valid_o  (commit_valid_o),
    .commit_id_o     (commit_id_o),
    .commit_valid2_o (commit_valid2_o),
    .commit_id2_o    (commit_id2_o),
    .busy_o          (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    src_valid_i   = '0;
    src_id_i      = '0;
    src_rd_we_i   = '0;
    src_rd_addr_i = '0;
    src_rd_data_i = '0;
  endtask

  task automatic do_reset();
    clr();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic offer(input int s, input logic [3:0] id, input logic we,
                       input logic [4:0] rd, input logic [31:0] d);
    src_valid_i[s]   = 1'b1;
    src_id_i[s]      = id;
    src_rd_we_i[s]   = we;
    src_rd_addr_i[s] = rd;
    src_rd_data_i[s] = d;
  endtask

  initial begin
    do_reset();
    chk("rst_ready", 64'(src_ready_o), 64'hF);
    chk("rst_busy", 64'(busy_o), 0);
    chk("rst_cv", 64'(commit_valid_o), 0);
    chk("rst_cv2", 64'(commit_valid2_o), 0);
    chk("rst_we", 64'(reg_we_o), 0);

    // single MUL completion, 2-cycle latency
    offer(SRC_MUL, 4'd3, 1'b1, 5'd5, 32'hDEADBEEF);
    step();
    clr();
    chk("mul_c1_cv", 64'(commit_valid_o), 0);
    step();
    chk("mul_we", 64'(reg_we_o), 1);
    chk("mul_waddr", 64'(reg_waddr_o), 5);
    chk("mul_wdata", 64'(reg_wdata_o), 64'hDEADBEEF);
    chk("mul_cv", 64'(commit_valid_o), 1);
    chk("mul_id", 64'(commit_id_o), 3);
    chk("mul_cv2", 64'(commit_valid2_o), 0);
    chk("mul_we2", 64'(reg_we2_o), 0);
    chk("mul_waddr2", 64'(reg_waddr2_o), 0);
    step();
    chk("mul_pulse", 64'(commit_valid_o), 0);
    chk("mul_idle_id", 64'(commit_id_o), 0);

    // all four sources at once
    do_reset();
    for (int s = 0; s < NSRC; s++)
      offer(s, 4'(s), 1'b1, 5'(s + 1), 32'h100 + 32'(s));
    step();
    clr();
    step();
    chk("four_c2_id", 64'(commit_id_o), 0);
    chk("four_c2_id2", 64'(commit_id2_o), 1);
    chk("four_c2_cv2", 64'(commit_valid2_o), 1);
    chk("four_c2_wd2", 64'(reg_wdata2_o), 64'h101);
    step();
    chk("four_c3_id", 64'(commit_id_o), 2);
    chk("four_c3_id2", 64'(commit_id2_o), 3);
    chk("four_c3_cv", 64'(commit_valid_o), 1);
    chk("four_c3_busy", 64'(busy_o), 0);
    step();
    chk("four_c4_cv", 64'(commit_valid_o), 0);

    // DIV and LSU both target x7
    do_reset();
    offer(SRC_DIV, 4'd1, 1'b1, 5'd7, 32'hAAAA_0001);
    offer(SRC_LSU, 4'd2, 1'b1, 5'd7, 32'hBBBB_0002);
    step();
    clr();
    step();
    chk("war_c2_id", 64'(commit_id_o), 1);
    chk("war_c2_wd", 64'(reg_wdata_o), 64'hAAAA_0001);
    chk("war_c2_cv2", 64'(commit_valid2_o), 0);
    step();
    chk("war_c3_cv", 64'(commit_valid_o), 1);
    chk("war_c3_id", 64'(commit_id_o), 2);
    chk("war_c3_wa", 64'(reg_waddr_o), 7);
    chk("war_c3_wd", 64'(reg_wdata_o), 64'hBBBB_0002);

    // non-writing commits
    do_reset();
    offer(SRC_CSR, 4'd6, 1'b0, 5'd9, 32'h1234);
    offer(SRC_LSU, 4'd2, 1'b1, 5'd0, 32'h5678);
    step();
    clr();
    step();
    chk("nw_cv", 64'(commit_valid_o), 1);
    chk("nw_id", 64'(commit_id_o), 2);
    chk("nw_cv2", 64'(commit_valid2_o), 1);
    chk("nw_id2", 64'(commit_id2_o), 6);
    chk("nw_we", 64'(reg_we_o), 0);
    chk("nw_we2", 64'(reg_we2_o), 0);

    // MUL streaming for 10 cycles
    do_reset();
    for (int c = 0; c < 12; c++) begin
      clr();
      if (c < 10) begin
        offer(SRC_MUL, 4'(c), 1'b1, 5'd3, 32'(c) + 32'h50);
        chk("strm_ready", 64'(src_ready_o[0]), 1);
      end
      step();
      if (c >= 1 && c <= 10) begin
        chk("strm_cv", 64'(commit_valid_o), 1);
        chk("strm_id", 64'(commit_id_o), 64'(c - 1));
      end else if (c == 11) begin
        chk("strm_end", 64'(commit_valid_o), 0);
      end
    end
    clr();

    // reset mid-operation
    do_reset();
    offer(SRC_DIV, 4'd1, 1'b1, 5'd4, 32'h11);
    step();
    offer(SRC_DIV, 4'd2, 1'b1, 5'd4, 32'h22);
    step();
    clr();
    chk("mr_busy_pre", 64'(busy_o), 1);
    chk("mr_id_pre", 64'(commit_id_o), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mr_busy", 64'(busy_o), 0);
    chk("mr_cv", 64'(commit_valid_o), 0);
    chk("mr_cv2", 64'(commit_valid2_o), 0);
    chk("mr_ready", 64'(src_ready_o), 64'hF);
    step();
    chk("mr_drop", 64'(commit_valid_o), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
